// File: rtl/dp_pkg.sv
// Shared types and constants for the DP segment-selection stage.
// The overflow mode (DP_SATURATE_EN) is applied inside dp_sat_add3, not here.
package dp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WRITE = 2'd2
    } dp_state_e;

    localparam int DP_BIT_WIDTH = 32;
    localparam logic signed [DP_BIT_WIDTH-1:0] COST_MAX = {1'b0, {(DP_BIT_WIDTH-1){1'b1}}};
    localparam logic signed [DP_BIT_WIDTH-1:0] COST_MIN = {1'b1, {(DP_BIT_WIDTH-1){1'b0}}};

    // Cycles from cost_rd_addr being driven to cost_rd_data being usable.
    localparam int COST_RD_LAT = 2;

endpackage

// File: rtl/dp_sat_add3.sv
// Combinational three-operand signed add.
// DP_SATURATE_EN defined: the result is clamped to the W-bit range; otherwise it wraps.
module dp_sat_add3 #(
    parameter int W = 32
) (
    input  logic signed [W-1:0] a_in,
    input  logic signed [W-1:0] b_in,
    input  logic signed [W-1:0] c_in,
    output logic signed [W-1:0] sum_out
);

`ifdef DP_SATURATE_EN
    localparam logic signed [W+1:0] MAX_EXT = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MIN_EXT = {3'b111, {(W-1){1'b0}}};

    logic signed [W+1:0] full;

    always_comb begin
        // Two guard bits hold the worst case of three W-bit operands.
        full = {{2{a_in[W-1]}}, a_in} + {{2{b_in[W-1]}}, b_in} + {{2{c_in[W-1]}}, c_in};
        if (full > MAX_EXT) begin
            sum_out = {1'b0, {(W-1){1'b1}}};
        end else if (full < MIN_EXT) begin
            sum_out = {1'b1, {(W-1){1'b0}}};
        end else begin
            sum_out = full[W-1:0];
        end
    end
`else
    always_comb begin
        sum_out = a_in + b_in + c_in;
    end
`endif

endmodule

// File: rtl/dp_segment_select.sv
// DP selection stage: cost[i] = min over j of cost[j-1] + E_min(j,i) + SEG_PENALTY, with argmin j.
// Overflow behaviour of the sum is selected by DP_SATURATE_EN (clamp) versus default (wrap).
module dp_segment_select
    import dp_pkg::*;
#(
    parameter int BIT_WIDTH = DP_BIT_WIDTH,
    parameter int I = 160,
    parameter logic signed [BIT_WIDTH-1:0] SEG_PENALTY = '0,
    localparam int IW = $clog2(I)
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        start_in,
    input  logic [IW-1:0]               i_in,
    input  logic                        emin_valid_in,
    input  logic [IW-1:0]               j_in,
    input  logic signed [BIT_WIDTH-1:0] emin_in,
    output logic [IW-1:0]               cost_rd_addr,
    input  logic signed [BIT_WIDTH-1:0] cost_rd_data,
    output logic                        cost_wr_en,
    output logic [IW-1:0]               cost_wr_addr,
    output logic signed [BIT_WIDTH-1:0] cost_wr_data,
    output logic [IW-1:0]               bp_wr_data,
    output logic                        done_out,
    output logic                        busy_out,
    output logic                        error_out
);

    localparam int P = COST_RD_LAT + 1;
    localparam logic signed [BIT_WIDTH-1:0] BEST_INIT = {1'b0, {(BIT_WIDTH-1){1'b1}}};

    dp_state_e state_q, state_d;
    logic [IW-1:0] i_q, i_d, best_j_q, best_j_d, rd_addr_q, rd_addr_d;
    logic [IW:0] exp_j_q, exp_j_d;
    logic signed [BIT_WIDTH-1:0] best_cost_q, best_cost_d;
    logic error_q, error_d, busy_q, busy_d, done_q, done_d;

    logic p_valid_q [P], p_valid_d [P];
    logic p_j0_q [P], p_j0_d [P];
    logic p_last_q [P], p_last_d [P];
    logic [IW-1:0] p_j_q [P], p_j_d [P];
    logic signed [BIT_WIDTH-1:0] p_emin_q [P], p_emin_d [P];

    logic cand_valid_q, cand_valid_d, cand_last_q, cand_last_d;
    logic [IW-1:0] cand_j_q, cand_j_d;
    logic signed [BIT_WIDTH-1:0] cand_q, cand_d;

    logic accept;
    logic signed [BIT_WIDTH-1:0] cost_term, sum;

    // Sample stream has no ready: a sample is taken on emin_valid_in only in ACCUM and only
    // when it carries the next expected j (<= i); anything else is dropped and flags error_out.
    assign accept = (state_q == ACCUM) && emin_valid_in &&
                    ({1'b0, j_in} == exp_j_q) && (j_in <= i_q);

    assign cost_term = p_j0_q[P-1] ? '0 : cost_rd_data;

    dp_sat_add3 #(.W(BIT_WIDTH)) u_add (
        .a_in    (cost_term),
        .b_in    (p_emin_q[P-1]),
        .c_in    (SEG_PENALTY),
        .sum_out (sum)
    );

    always_comb begin
        p_valid_d[0] = accept;
        p_j_d[0]     = j_in;
        p_emin_d[0]  = emin_in;
        p_j0_d[0]    = (j_in == '0);
        p_last_d[0]  = (j_in == i_q);
        for (int k = 1; k < P; k++) begin
            p_valid_d[k] = p_valid_q[k-1];
            p_j_d[k]     = p_j_q[k-1];
            p_emin_d[k]  = p_emin_q[k-1];
            p_j0_d[k]    = p_j0_q[k-1];
            p_last_d[k]  = p_last_q[k-1];
        end
        cand_valid_d = p_valid_q[P-1];
        cand_j_d     = p_j_q[P-1];
        cand_last_d  = p_last_q[P-1];
        cand_d       = sum;
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        exp_j_d     = exp_j_q;
        best_cost_d = best_cost_q;
        best_j_d    = best_j_q;
        rd_addr_d   = rd_addr_q;
        error_d     = error_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d     = ACCUM;
                    i_d         = i_in;
                    exp_j_d     = '0;
                    best_cost_d = BEST_INIT;
                    best_j_d    = '0;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ACCUM: begin
                if (accept) begin
                    exp_j_d   = exp_j_q + 1'b1;
                    rd_addr_d = (j_in == '0) ? '0 : j_in - 1'b1;
                end else if (emin_valid_in) begin
                    error_d = 1'b1;
                end
                // Strict less-than keeps the earliest j on ties.
                if (cand_valid_q && (cand_q < best_cost_q)) begin
                    best_cost_d = cand_q;
                    best_j_d    = cand_j_q;
                end
                if (cand_valid_q && cand_last_q) begin
                    state_d = WRITE;
                    done_d  = 1'b1;
                end
            end
            WRITE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            i_q          <= '0;
            exp_j_q      <= '0;
            best_cost_q  <= '0;
            best_j_q     <= '0;
            rd_addr_q    <= '0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cand_valid_q <= 1'b0;
            cand_last_q  <= 1'b0;
            cand_j_q     <= '0;
            cand_q       <= '0;
            for (int k = 0; k < P; k++) begin
                p_valid_q[k] <= 1'b0;
                p_j0_q[k]    <= 1'b0;
                p_last_q[k]  <= 1'b0;
                p_j_q[k]     <= '0;
                p_emin_q[k]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            exp_j_q      <= exp_j_d;
            best_cost_q  <= best_cost_d;
            best_j_q     <= best_j_d;
            rd_addr_q    <= rd_addr_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cand_valid_q <= cand_valid_d;
            cand_last_q  <= cand_last_d;
            cand_j_q     <= cand_j_d;
            cand_q       <= cand_d;
            for (int k = 0; k < P; k++) begin
                p_valid_q[k] <= p_valid_d[k];
                p_j0_q[k]    <= p_j0_d[k];
                p_last_q[k]  <= p_last_d[k];
                p_j_q[k]     <= p_j_d[k];
                p_emin_q[k]  <= p_emin_d[k];
            end
        end
    end

    assign cost_rd_addr = rd_addr_q;
    assign cost_wr_en   = done_q;
    assign done_out     = done_q;
    assign cost_wr_addr = i_q;
    assign cost_wr_data = best_cost_q;
    assign bp_wr_data   = best_j_q;
    assign busy_out     = busy_q;
    assign error_out    = error_q;

endmodule

// File: doc/dp_segment_select.md
# dp_segment_select

Dynamic-programming selection stage directly downstream of the E_min engine. For one target index i it consumes the in-order stream of E_min(j, i) for j = 0..i and fetches cost[j-1] from the shared DP cost memory, with cost[-1] = 0. It forms cand(j) = cost[j-1] + E_min(j, i) + SEG_PENALTY, tracks the minimum and its argmin j, and writes cost[i] and backpointer[i] once the stream ends. The top-level sequencer loops i upward, pulsing start_in and waiting for done_out before advancing.

## Interface
- BIT_WIDTH, 32, width of E_min, cost and penalty values (signed two's complement)
- I, 160, number of sample points; index width IW = $clog2(I)
- SEG_PENALTY, 0, signed per-segment cost added to every candidate
- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-high
- start_in  input  1  one-cycle start; sampled only in IDLE
- i_in  input  IW  target index, captured with start_in
- emin_valid_in  input  1  E_min sample valid (emin's output_valid)
- j_in  input  IW  segment start index of the sample (emin's j_out)
- emin_in  input  BIT_WIDTH  E_min(j, i) (emin's data_out)
- cost_rd_addr  output  IW  cost memory read address, registered
- cost_rd_data  input  BIT_WIDTH  cost memory read data, valid 2 cycles after cost_rd_addr
- cost_wr_en  output  1  one-cycle write strobe for cost[i]
- cost_wr_addr  output  IW  equals the captured i
- cost_wr_data  output  BIT_WIDTH  minimum candidate
- bp_wr_data  output  IW  argmin j, written alongside cost
- done_out  output  1  one-cycle pulse, coincident with cost_wr_en
- busy_out  output  1  high in ACCUM and WRITE
- error_out  output  1  sticky out-of-order flag; cleared by the next accepted start_in

## Operation
- States: IDLE -> ACCUM on start_in; ACCUM -> WRITE when the j == i candidate leaves the compare stage; WRITE -> IDLE after one cycle.
- On start: i_reg <= i_in; exp_j <= 0; best_cost <= most-positive BIT_WIDTH value; best_j <= 0; error_out <= 0.
- In ACCUM, a sample is accepted only when emin_valid_in is high and j_in == exp_j. An accepted sample increments exp_j, issues cost_rd_addr = j-1, and enters a pipe carrying j, emin_in and a j0 flag. For j = 0, cost_rd_addr = 0 and the response is replaced by 0.
- Mismatch (j_in != exp_j, or j_in > i_reg): sample dropped, error_out set. The block stays in ACCUM until a matching j == i arrives or rst_in is asserted.
- emin_valid_in is ignored in IDLE and WRITE. start_in is ignored outside IDLE.
- Sum stage: cand = cost_term + emin + SEG_PENALTY, computed in BIT_WIDTH+2 bits, then reduced (see Configuration).
- Compare stage: strict cand < best_cost updates best_cost and best_j. On a tie the earlier (smaller) j is kept.
- WRITE: cost_wr_en = done_out = 1, cost_wr_addr = i_reg, cost_wr_data = best_cost, bp_wr_data = best_j.
- Reset values: all outputs 0, state IDLE, pipe valids cleared. Reset mid-ACCUM abandons i with no write.
- Reads for i only touch cost[0..i-1], so there is no read/write hazard with cost[i].

## Timing
- Throughput: one sample per cycle, no backpressure; bubbles allowed.
- Sample accepted in cycle t -> cost_rd_addr driven in t+1 -> cost_rd_data used in t+3 -> cand registered t+4 -> best updated t+5.
- Last sample (j = i) accepted in cycle t -> cost_wr_en/done_out high in cycle t+5, busy_out low from t+6.
- start_in may be reasserted in the cycle after done_out.

## Configuration
- DP_SATURATE_EN defined: the sum is clamped to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
- Undefined: the sum is truncated to BIT_WIDTH bits (two's-complement wrap). The block is smaller, but overflow is undetected.

## Structure
- Package dp_pkg: state enum (IDLE, ACCUM, WRITE), COST_MAX/COST_MIN localparams, and the read-latency constant COST_RD_LAT = 2.
- One sub-module, dp_sat_add3: combinational three-operand signed add with the saturation macro applied inside it.

## Test plan
- i = 0, emin = 50, SEG_PENALTY = 10 -> one write: cost[0] = 60, bp = 0, done_out 5 cycles after the sample.
- i = 3, cost[0..2] = {5, 7, 100}, emin j = 0..3 = {40, 30, 20, 1}, penalty 0 -> cands {40, 35, 27, 101}; writes cost[3] = 27, bp = 2.
- Tie: i = 1, cost[0] = 10, emin = {20, 10} -> both cands 20; bp = 0.
- Sample sequence j = 0, 2 for i = 2 -> error_out high, no write; rst_in then returns the block to IDLE with all outputs 0.
- Overflow: cost[0] = 2^31-10, emin j = 1 = 100, emin j = 0 = 2^31-1, i = 1. With DP_SATURATE_EN, cost[1] = 2^31-1 (bp = 0, tie kept). Without it, the j = 1 cand wraps negative and is selected (bp = 1).
- Back-to-back: i = 1 then i = 2, with start_in the cycle after done_out and bubbles inserted between samples -> both writes correct, and the i = 2 run reads the freshly written cost[1].
